// File: rtl/axi4lite_bram_slave_if.sv
// ---------------------------------------------------------------------------
// axi4lite_bram_slave_if
//
// AXI4-Lite bus bundle for the BRAM-backed slave. It carries the five
// channels (AW, W, B, AR, R). The clock and reset are not part of the bundle.
//
// Modports:
//   master : drives addresses, write data, strobes, the VALIDs and the
//            B/R READYs.
//   slave  : drives AWREADY/WREADY/ARREADY, BRESP/BVALID and
//            RDATA/RRESP/RVALID.
//
// Parameters:
//   DATA_WIDTH : data bus width in bits (32 or 64).
//   ADDR_WIDTH : byte address width.
// ---------------------------------------------------------------------------
interface axi4lite_bram_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   // write address channel
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   // write data channel
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   // write response channel
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   // read address channel
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   // read data channel
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi4lite_bram_slave.sv
// ---------------------------------------------------------------------------
// axi4lite_bram_slave
//
// AXI4-Lite slave in front of an inferred single-port block RAM of C_DEPTH
// words. It handles one transaction at a time. Writes use byte strobes. Reads
// have a configurable BRAM output latency of 1 or 2 register stages. When a
// read and a write arrive in the same cycle, a round-robin flag picks which
// one is served. An access whose word index is C_DEPTH or higher gets SLVERR.
// Such a write does not change memory, and such a read returns zero.
//
// Ports:
//   ACLK   : clock; all logic is rising-edge.
//   ARESET : asynchronous, active-high reset. Memory contents are kept.
//   s_axi  : AXI4-Lite slave bundle (axi4lite_bram_slave_if.slave).
//
// Parameters:
//   C_S_AXI_DATA_WIDTH : 32 or 64.
//   C_S_AXI_ADDR_WIDTH : byte address width.
//   C_DEPTH            : number of words. It must not exceed the range that
//                        the word index can address.
//   C_READ_LATENCY     : 1 or 2 BRAM output register stages.
// ---------------------------------------------------------------------------
module axi4lite_bram_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 12,
   parameter int C_DEPTH            = 256,
   parameter int C_READ_LATENCY     = 1
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   axi4lite_bram_slave_if.slave  s_axi
);

   localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
   localparam int MEM_AW   = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;

   localparam logic [IDX_W:0] DEPTH_CMP = (IDX_W + 1)'(C_DEPTH);
   localparam logic           LAT_LAST  = (C_READ_LATENCY == 2) ? 1'b1 : 1'b0;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WACK  = 3'd1;
   localparam logic [2:0] ST_WRESP = 3'd2;
   localparam logic [2:0] ST_RWAIT = 3'd3;
   localparam logic [2:0] ST_RRESP = 3'd4;

   logic [2:0]                    state_reg;
   logic                          prio_wr_reg;
   logic                          awready_reg;
   logic                          wready_reg;
   logic                          arready_reg;
   logic                          bvalid_reg;
   logic                          rvalid_reg;
   logic [1:0]                    bresp_reg;
   logic [1:0]                    rresp_reg;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;
   logic [IDX_W-1:0]              idx_reg;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_reg;
   logic [STRB_W-1:0]             wstrb_reg;
   logic                          lat_cnt_reg;

   logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:C_DEPTH-1];
   logic [C_S_AXI_DATA_WIDTH-1:0] mem_rd_reg;
   logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
   logic [MEM_AW-1:0]             rd_addr;
   logic [MEM_AW-1:0]             wr_addr;
   logic [STRB_W-1:0]             lane_we;

   logic [IDX_W-1:0]              aw_idx;
   logic [IDX_W-1:0]              ar_idx;
   logic                          wr_req;
   logic                          rd_req;
   logic                          serve_wr;
   logic                          serve_rd;
   logic                          in_range;

   // ------------------------------------------------------------------
   // Request decode and arbitration (evaluated only in IDLE)
   // ------------------------------------------------------------------
   assign aw_idx = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
   assign ar_idx = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

   // A write needs both address and data present. A lone AW or W is not
   // accepted.
   assign wr_req   = s_axi.awvalid & s_axi.wvalid;
   assign rd_req   = s_axi.arvalid;
   assign serve_wr = wr_req & (~rd_req |  prio_wr_reg);
   assign serve_rd = rd_req & (~wr_req | ~prio_wr_reg);

   assign in_range = {1'b0, idx_reg} < DEPTH_CMP;

   // ------------------------------------------------------------------
   // Block RAM
   // ------------------------------------------------------------------
   // In IDLE the read port already follows the incoming AR address. This
   // means the first output register holds the word by the time the FSM
   // enters RWAIT. After that the port stays on the latched index.
   always_comb begin
      rd_addr = idx_reg[MEM_AW-1:0];
      if (state_reg == ST_IDLE)
         rd_addr = s_axi.araddr[ADDR_LSB +: MEM_AW];
   end

   assign wr_addr = idx_reg[MEM_AW-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < STRB_W; gi++) begin : g_lane_we
         assign lane_we[gi] = (state_reg == ST_WACK) & in_range & wstrb_reg[gi];
      end
   endgenerate

   // Byte-enable write plus registered read. Memory has no reset, so a word
   // committed in WACK survives a later ARESET.
   always_ff @(posedge ACLK) begin
      for (int i = 0; i < STRB_W; i++) begin
         if (lane_we[i])
            mem[wr_addr][i*8 +: 8] <= wdata_reg[i*8 +: 8];
      end
      mem_rd_reg <= mem[rd_addr];
   end

   generate
      if (C_READ_LATENCY == 2) begin : g_lat2
         logic [C_S_AXI_DATA_WIDTH-1:0] mem_pipe_reg;
         always_ff @(posedge ACLK) begin
            mem_pipe_reg <= mem_rd_reg;
         end
         assign rd_word = mem_pipe_reg;
      end else begin : g_lat1
         assign rd_word = mem_rd_reg;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Transaction FSM; every bus output comes straight from a register
   // ------------------------------------------------------------------
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_reg   <= ST_IDLE;
         prio_wr_reg <= 1'b1;
         awready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         arready_reg <= 1'b0;
         bvalid_reg  <= 1'b0;
         rvalid_reg  <= 1'b0;
         bresp_reg   <= RESP_OKAY;
         rresp_reg   <= RESP_OKAY;
         rdata_reg   <= '0;
         idx_reg     <= '0;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
         lat_cnt_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (serve_wr) begin
                  state_reg   <= ST_WACK;
                  awready_reg <= 1'b1;
                  wready_reg  <= 1'b1;
                  idx_reg     <= aw_idx;
                  wdata_reg   <= s_axi.wdata;
                  wstrb_reg   <= s_axi.wstrb;
               end else if (serve_rd) begin
                  state_reg   <= ST_RWAIT;
                  arready_reg <= 1'b1;
                  idx_reg     <= ar_idx;
                  lat_cnt_reg <= 1'b0;
               end
               // The flag moves only when both request types compete.
               if (wr_req && rd_req)
                  prio_wr_reg <= ~prio_wr_reg;
            end

            ST_WACK: begin
               // The AW/W handshake completes on this edge. The memory array
               // commits the enabled lanes on the same edge.
               awready_reg <= 1'b0;
               wready_reg  <= 1'b0;
               bvalid_reg  <= 1'b1;
               bresp_reg   <= in_range ? RESP_OKAY : RESP_SLVERR;
               state_reg   <= ST_WRESP;
            end

            ST_WRESP: begin
               if (s_axi.bready) begin
                  bvalid_reg <= 1'b0;
                  bresp_reg  <= RESP_OKAY;
                  state_reg  <= ST_IDLE;
               end
            end

            ST_RWAIT: begin
               arready_reg <= 1'b0;
               if (lat_cnt_reg == LAT_LAST) begin
                  state_reg  <= ST_RRESP;
                  rvalid_reg <= 1'b1;
                  rdata_reg  <= in_range ? rd_word : '0;
                  rresp_reg  <= in_range ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  lat_cnt_reg <= lat_cnt_reg + 1'b1;
               end
            end

            ST_RRESP: begin
               if (s_axi.rready) begin
                  rvalid_reg <= 1'b0;
                  state_reg  <= ST_IDLE;
               end
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign s_axi.awready = awready_reg;
   assign s_axi.wready  = wready_reg;
   assign s_axi.arready = arready_reg;
   assign s_axi.bvalid  = bvalid_reg;
   assign s_axi.bresp   = bresp_reg;
   assign s_axi.rvalid  = rvalid_reg;
   assign s_axi.rresp   = rresp_reg;
   assign s_axi.rdata   = rdata_reg;

   // The protection bits and the byte-offset address bits do not affect the
   // design.
   logic unused_bits;
   assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                          s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi4lite_bram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_bram_slave
//
// Directed bench for axi4lite_bram_slave (32-bit data, 12-bit address,
// 256 words, 2-cycle read latency). Each scenario task drives the bus and
// compares the observed values against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_axi4lite_bram_slave;

   localparam int DW    = 32;
   localparam int AW    = 12;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic aclk = 1'b0;
   logic rst  = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 aclk = ~aclk;

   axi4lite_bram_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

   axi4lite_bram_slave #(
      .C_S_AXI_DATA_WIDTH(DW),
      .C_S_AXI_ADDR_WIDTH(AW),
      .C_DEPTH(DEPTH),
      .C_READ_LATENCY(LAT)
   ) dut (
      .ACLK(aclk),
      .ARESET(rst),
      .s_axi(bif)
   );

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   // Bounded wait: 0=awready&wready, 1=bvalid, 2=arready, 3=rvalid.
   // Returns the number of cycles stepped, or -1 if the wait timed out.
   task automatic wait_high(input string name, input int sel, output int n);
      logic s;
      n = -1;
      for (int k = 0; k <= 20; k++) begin
         case (sel)
            0:       s = bif.awready & bif.wready;
            1:       s = bif.bvalid;
            2:       s = bif.arready;
            default: s = bif.rvalid;
         endcase
         if (s === 1'b1) begin
            n = k;
            break;
         end
         step();
      end
      if (n < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: no response within 20 cycles", name);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, output logic [1:0] resp,
                           output int aw_c, output int b_c);
      int n;
      resp = 2'bxx; aw_c = -1; b_c = -1;
      bif.awaddr = a; bif.wdata = d; bif.wstrb = s;
      bif.awvalid = 1'b1; bif.wvalid = 1'b1; bif.bready = 1'b1;
      step();
      wait_high("awready", 0, n);
      if (n >= 0) begin
         aw_c = 1 + n;
         step();
         bif.awvalid = 1'b0; bif.wvalid = 1'b0;
         wait_high("bvalid", 1, n);
         if (n >= 0) begin
            b_c  = aw_c + 1 + n;
            resp = bif.bresp;
         end
      end
      step();
      bif.awvalid = 1'b0; bif.wvalid = 1'b0; bif.bready = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                          output logic [1:0] resp, output int ar_c, output int r_c);
      int n;
      d = 'x; resp = 2'bxx; ar_c = -1; r_c = -1;
      bif.araddr = a; bif.arvalid = 1'b1; bif.rready = 1'b1;
      step();
      wait_high("arready", 2, n);
      if (n >= 0) begin
         ar_c = 1 + n;
         step();
         bif.arvalid = 1'b0;
         wait_high("rvalid", 3, n);
         if (n >= 0) begin
            r_c  = ar_c + 1 + n;
            d    = bif.rdata;
            resp = bif.rresp;
         end
      end
      step();
      bif.arvalid = 1'b0; bif.rready = 1'b0;
   endtask

   // Raises a write to 0x20 and a read of 0x20 in the same cycle.
   task automatic tie_round(input logic [DW-1:0] wd, output int aw_at, output int ar_at,
                            output logic [DW-1:0] rd, output logic [1:0] rr);
      logic got_b, got_r, drop_aw, drop_ar;
      aw_at = -1; ar_at = -1; rd = 'x; rr = 2'bxx;
      got_b = 0; got_r = 0; drop_aw = 0; drop_ar = 0;
      bif.awaddr = 12'h020; bif.wdata = wd; bif.wstrb = 4'hF;
      bif.araddr = 12'h020;
      bif.awvalid = 1'b1; bif.wvalid = 1'b1; bif.arvalid = 1'b1;
      bif.bready = 1'b1; bif.rready = 1'b1;
      for (int c = 1; c <= 40 && !(got_b && got_r); c++) begin
         step();
         if (drop_aw) begin bif.awvalid = 1'b0; bif.wvalid = 1'b0; drop_aw = 0; end
         if (drop_ar) begin bif.arvalid = 1'b0; drop_ar = 0; end
         if (bif.awready && bif.awvalid) begin aw_at = c; drop_aw = 1; end
         if (bif.arready && bif.arvalid) begin ar_at = c; drop_ar = 1; end
         if (bif.bvalid) got_b = 1;
         if (bif.rvalid && !got_r) begin got_r = 1; rd = bif.rdata; rr = bif.rresp; end
      end
      if (!(got_b && got_r)) begin
         vectors++;
         miscompares++;
         $display("FAIL tie_timeout: b=%0d r=%0d required both 1", got_b, got_r);
      end
      step();
      bif.awvalid = 1'b0; bif.wvalid = 1'b0; bif.arvalid = 1'b0;
      bif.bready = 1'b0; bif.rready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      vectors++;
      if ({bif.awready, bif.wready, bif.arready, bif.bvalid, bif.rvalid} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_handshake: got %b required 00000",
                  {bif.awready, bif.wready, bif.arready, bif.bvalid, bif.rvalid});
      end
      vectors++;
      if ({bif.bresp, bif.rresp} !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_resp: got %b required 0000", {bif.bresp, bif.rresp});
      end
      vectors++;
      if (bif.rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_rdata: got %h required 00000000", bif.rdata);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_arbitration();
      int aw_at, ar_at;
      logic [DW-1:0] rd;
      logic [1:0] rr, resp;
      int a, b;
      // Flag selects write after reset: write at cycle 1, read accepted at 4.
      tie_round(32'h55, aw_at, ar_at, rd, rr);
      $display("tie1: aw_at=%0d ar_at=%0d rdata=%h rresp=%b", aw_at, ar_at, rd, rr);
      vectors++;
      if (aw_at !== 1 || ar_at !== 4) begin
         miscompares++;
         $display("FAIL tie1_order: got aw=%0d ar=%0d required aw=1 ar=4", aw_at, ar_at);
      end
      vectors++;
      if (rd !== 32'h55 || rr !== 2'b00) begin
         miscompares++;
         $display("FAIL tie1_rdata: got %h/%b required 00000055/00", rd, rr);
      end
      // Flag toggled: read first (old data), write accepted at cycle 5.
      tie_round(32'h66, aw_at, ar_at, rd, rr);
      $display("tie2: aw_at=%0d ar_at=%0d rdata=%h rresp=%b", aw_at, ar_at, rd, rr);
      vectors++;
      if (ar_at !== 1 || aw_at !== 5) begin
         miscompares++;
         $display("FAIL tie2_order: got aw=%0d ar=%0d required aw=5 ar=1", aw_at, ar_at);
      end
      vectors++;
      if (rd !== 32'h55) begin
         miscompares++;
         $display("FAIL tie2_rdata: got %h required 00000055", rd);
      end
      do_read(12'h020, rd, resp, a, b);
      $display("read 0x020: rdata=%h rresp=%b", rd, resp);
      vectors++;
      if (rd !== 32'h66) begin
         miscompares++;
         $display("FAIL tie2_after: got %h required 00000066", rd);
      end
   endtask

   task automatic test_basic();
      logic [1:0] resp;
      logic [DW-1:0] rd;
      int c1, c2;
      for (int i = 0; i < 4; i++) begin
         do_write(AW'(i * 4), DW'(i + 1), 4'hF, resp, c1, c2);
         $display("write 0x%03h: bresp=%b aw_c=%0d b_c=%0d", i * 4, resp, c1, c2);
         vectors++;
         if (resp !== 2'b00 || c1 !== 1 || c2 !== 2) begin
            miscompares++;
            $display("FAIL basic_wr%0d: got resp=%b aw=%0d b=%0d required 00/1/2",
                     i, resp, c1, c2);
         end
      end
      for (int i = 0; i < 4; i++) begin
         do_read(AW'(i * 4), rd, resp, c1, c2);
         $display("read 0x%03h: rdata=%h rresp=%b ar_c=%0d r_c=%0d", i * 4, rd, resp, c1, c2);
         vectors++;
         if (rd !== DW'(i + 1) || resp !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_rd%0d: got %h/%b required %h/00", i, rd, resp, DW'(i + 1));
         end
         vectors++;
         if (c1 !== 1 || c2 !== 1 + LAT) begin
            miscompares++;
            $display("FAIL basic_rd_lat%0d: got ar=%0d r=%0d required ar=1 r=%0d",
                     i, c1, c2, 1 + LAT);
         end
      end
   endtask

   task automatic test_strobe();
      logic [1:0] resp;
      logic [DW-1:0] rd;
      int c1, c2;
      do_write(12'h010, 32'hAABBCCDD, 4'hF, resp, c1, c2);
      $display("write 0x010 strb=F: bresp=%b", resp);
      do_write(12'h010, 32'h11223344, 4'h5, resp, c1, c2);
      $display("write 0x010 strb=5: bresp=%b", resp);
      do_read(12'h010, rd, resp, c1, c2);
      $display("read 0x010: rdata=%h rresp=%b", rd, resp);
      vectors++;
      if (rd !== 32'hAA22CC44) begin
         miscompares++;
         $display("FAIL strobe_merge: got %h required aa22cc44", rd);
      end
   endtask

   task automatic test_out_of_range();
      logic [1:0] resp;
      logic [DW-1:0] rd;
      int c1, c2;
      do_write(12'h3FC, 32'h12345678, 4'hF, resp, c1, c2);
      $display("write 0x3fc: bresp=%b", resp);
      vectors++;
      if (resp !== 2'b00) begin
         miscompares++;
         $display("FAIL oor_last_wr: got %b required 00", resp);
      end
      do_write(12'h400, 32'hDEADBEEF, 4'hF, resp, c1, c2);
      $display("write 0x400: bresp=%b", resp);
      vectors++;
      if (resp !== 2'b10 || c2 !== 2) begin
         miscompares++;
         $display("FAIL oor_wr: got %b b=%0d required 10 b=2", resp, c2);
      end
      do_read(12'h400, rd, resp, c1, c2);
      $display("read 0x400: rdata=%h rresp=%b", rd, resp);
      vectors++;
      if (rd !== 32'h0 || resp !== 2'b10) begin
         miscompares++;
         $display("FAIL oor_rd: got %h/%b required 00000000/10", rd, resp);
      end
      do_read(12'h3FC, rd, resp, c1, c2);
      $display("read 0x3fc: rdata=%h rresp=%b", rd, resp);
      vectors++;
      if (rd !== 32'h12345678 || resp !== 2'b00) begin
         miscompares++;
         $display("FAIL oor_last_rd: got %h/%b required 12345678/00", rd, resp);
      end
      do_read(12'h000, rd, resp, c1, c2);
      $display("read 0x000: rdata=%h rresp=%b", rd, resp);
      vectors++;
      if (rd !== 32'h1) begin
         miscompares++;
         $display("FAIL oor_no_alias: got %h required 00000001", rd);
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [1:0] resp;
      logic [DW-1:0] rd;
      int c1, c2;
      // B channel stall with a pending read
      bif.awaddr = 12'h030; bif.wdata = 32'hCAFE0001; bif.wstrb = 4'hF;
      bif.awvalid = 1'b1; bif.wvalid = 1'b1; bif.bready = 1'b0;
      step();
      wait_high("bp_awready", 0, n);
      step();
      bif.awvalid = 1'b0; bif.wvalid = 1'b0;
      wait_high("bp_bvalid", 1, n);
      bif.araddr = 12'h030; bif.arvalid = 1'b1; bif.rready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         vectors++;
         if ({bif.bvalid, bif.bresp, bif.arready} !== 4'b1_00_0) begin
            miscompares++;
            $display("FAIL bp_bstall%0d: got bvalid,bresp,arready=%b required 1000",
                     k, {bif.bvalid, bif.bresp, bif.arready});
         end
      end
      $display("b stall: 5 cycles held");
      bif.bready = 1'b1;
      step();
      bif.bready = 1'b0;
      vectors++;
      if (bif.bvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_bdone: got bvalid=%b required 0", bif.bvalid);
      end
      // R channel stall with a pending write
      wait_high("bp_arready", 2, n);
      step();
      bif.arvalid = 1'b0;
      wait_high("bp_rvalid", 3, n);
      vectors++;
      if (bif.rdata !== 32'hCAFE0001) begin
         miscompares++;
         $display("FAIL bp_rdata: got %h required cafe0001", bif.rdata);
      end
      bif.awaddr = 12'h034; bif.wdata = 32'hCAFE0002;
      bif.awvalid = 1'b1; bif.wvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         vectors++;
         if (bif.rvalid !== 1'b1 || bif.rdata !== 32'hCAFE0001 ||
             bif.rresp !== 2'b00 || bif.awready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_rstall%0d: got rvalid=%b rdata=%h rresp=%b awready=%b required 1/cafe0001/00/0",
                     k, bif.rvalid, bif.rdata, bif.rresp, bif.awready);
         end
      end
      $display("r stall: 5 cycles held");
      bif.rready = 1'b1;
      step();
      bif.rready = 1'b0;
      vectors++;
      if (bif.rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_rdone: got rvalid=%b required 0", bif.rvalid);
      end
      bif.bready = 1'b1;
      wait_high("bp_awready2", 0, n);
      step();
      bif.awvalid = 1'b0; bif.wvalid = 1'b0;
      wait_high("bp_bvalid2", 1, n);
      vectors++;
      if (bif.bresp !== 2'b00) begin
         miscompares++;
         $display("FAIL bp_wr2: got %b required 00", bif.bresp);
      end
      step();
      bif.bready = 1'b0;
      do_read(12'h034, rd, resp, c1, c2);
      $display("read 0x034: rdata=%h rresp=%b", rd, resp);
      vectors++;
      if (rd !== 32'hCAFE0002) begin
         miscompares++;
         $display("FAIL bp_rd2: got %h required cafe0002", rd);
      end
   endtask

   task automatic test_reset_midop();
      int n;
      logic [1:0] resp;
      logic [DW-1:0] rd;
      int c1, c2;
      // Reset while BVALID is pending: must clear asynchronously; write retained.
      bif.awaddr = 12'h040; bif.wdata = 32'h77; bif.wstrb = 4'hF;
      bif.awvalid = 1'b1; bif.wvalid = 1'b1; bif.bready = 1'b0;
      step();
      wait_high("rst_awready", 0, n);
      step();
      bif.awvalid = 1'b0; bif.wvalid = 1'b0;
      wait_high("rst_bvalid", 1, n);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (bif.bvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_async_b: got bvalid=%b required 0", bif.bvalid);
      end
      step(); step();
      rst = 1'b0;
      // Reset during RWAIT: RVALID must never rise for the dropped read.
      bif.araddr = 12'h000; bif.arvalid = 1'b1; bif.rready = 1'b1;
      step();
      wait_high("rst_arready", 2, n);
      step();
      bif.arvalid = 1'b0;
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({bif.arready, bif.rvalid} !== 2'b00) begin
         miscompares++;
         $display("FAIL rst_async_r: got arready,rvalid=%b required 00",
                  {bif.arready, bif.rvalid});
      end
      step(); step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         vectors++;
         if (bif.rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_dropped%0d: got rvalid=%b required 0", k, bif.rvalid);
         end
      end
      bif.rready = 1'b0;
      do_read(12'h040, rd, resp, c1, c2);
      $display("read 0x040: rdata=%h rresp=%b", rd, resp);
      vectors++;
      if (rd !== 32'h77) begin
         miscompares++;
         $display("FAIL rst_retained: got %h required 00000077", rd);
      end
      do_read(12'h000, rd, resp, c1, c2);
      $display("read 0x000: rdata=%h ar_c=%0d r_c=%0d", rd, c1, c2);
      vectors++;
      if (rd !== 32'h1 || c1 !== 1 || c2 !== 1 + LAT) begin
         miscompares++;
         $display("FAIL rst_fresh_rd: got %h ar=%0d r=%0d required 00000001 ar=1 r=%0d",
                  rd, c1, c2, 1 + LAT);
      end
   endtask

   initial begin
      bif.awaddr = '0; bif.awprot = 3'b0; bif.awvalid = 1'b0;
      bif.wdata = '0; bif.wstrb = '0; bif.wvalid = 1'b0; bif.bready = 1'b0;
      bif.araddr = '0; bif.arprot = 3'b0; bif.arvalid = 1'b0; bif.rready = 1'b0;
      test_reset();
      test_arbitration();
      test_basic();
      test_strobe();
      test_out_of_range();
      test_backpressure();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/axi4lite_bram_slave.md
Name: axi4lite_bram_slave

Overview:
Parametrised AXI4-Lite slave backed by an inferred single-port block RAM. It replaces the fixed four-register slave with a configurable-depth memory. It adds byte-strobe writes, configurable BRAM read latency, fair arbitration between reads and writes, and SLVERR for out-of-range accesses. It sits behind the AXI interconnect as a PS-accessible scratch/data buffer.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width in bits; 32 or 64 only.
C_S_AXI_ADDR_WIDTH, 12, byte address width.
C_DEPTH, 256, number of data words; must be ≤ 2^(C_S_AXI_ADDR_WIDTH - log2(C_S_AXI_DATA_WIDTH/8)).
C_READ_LATENCY, 1, BRAM output register stages; 1 or 2.

Ports:
ACLK  in  1  clock; all logic is rising-edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read byte address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.

Behaviour:
- Reset and clocking: one clock, ACLK. ARESET is asynchronous and active-high.
- Reset values: AWREADY, WREADY, ARREADY, BVALID and RVALID are 0. BRESP, RRESP and RDATA are 0. The FSM is in IDLE and the priority flag selects write. Memory contents are not reset.
- Word index: byte address bits [C_S_AXI_ADDR_WIDTH-1 : log2(bytes)]. The low byte-offset bits are ignored. Index ≥ C_DEPTH is out of range.
- FSM states: IDLE, WACK, WRESP, RWAIT, RRESP. Only one transaction is outstanding at a time.
- IDLE, write eligible: a write is eligible only when AWVALID and WVALID are both 1. AW alone or W alone is never accepted.
- IDLE, selection: if only one request type is eligible, serve it. If a write and a read are eligible in the same cycle, serve the type indicated by the priority flag, then toggle the flag (round-robin).
- WACK (one cycle): AWREADY=WREADY=1, so the handshake completes here.
  - In range: each byte lane with WSTRB=1 is written on this edge; lanes with WSTRB=0 keep their old value.
  - Out of range: no write.
  - Next state is WRESP.
- WRESP: BVALID=1, BRESP=00 (OKAY) or 10 (SLVERR). Hold until BREADY=1, then go to IDLE with BVALID=0 on the next cycle.
- Read accept: ARREADY=1 for one cycle on entry to RWAIT. The address is latched at that point.
- RWAIT: count C_READ_LATENCY cycles, then go to RRESP.
- RRESP: RVALID=1 with RDATA = memory word, RRESP=00. For out-of-range reads, RDATA=0 and RRESP=10. RDATA and RRESP stay stable until RREADY=1, then go to IDLE.
- Latency, with requests sampled in IDLE at cycle 0:
  - Write: handshake at cycle 1, BVALID at cycle 2.
  - Read: ARREADY at cycle 1, RVALID at cycle 1+C_READ_LATENCY.
  - Back-to-back: the earliest next acceptance is the cycle after the B or R handshake.
- Read-after-write: always returns the new data. Writes commit in WACK, before any later read.
- Reset mid-operation: the outstanding transaction is dropped and all outputs return to reset values. A write committed in WACK before reset is retained.
- No combinational path from any input to any READY or VALID output; all outputs are registered.

Test Plan:
- Writes of 0x00000001, 0x00000002, 0x00000003, 0x00000004 to 0x0, 0x4, 0x8, 0xC, WSTRB=0xF, then read back → each BRESP=OKAY; reads return 1, 2, 3, 4 with RRESP=OKAY.
- Write 0xAABBCCDD to 0x10 with WSTRB=0xF, then 0x11223344 with WSTRB=0x5, read 0x10 → 0xAA22CC44.
- Out-of-range, C_DEPTH=256: write 0xDEADBEEF to 0x400 → BRESP=10; read 0x400 → RDATA=0, RRESP=10; read 0x3FC → OKAY and unchanged.
- Simultaneous AWVALID/WVALID (0x20, 0x55) and ARVALID (0x20) after reset:
  - First: write served first; the read then returns 0x55.
  - Repeat the tie: the read is served first and the write second (flag toggled).
- Backpressure: BREADY held low 5 cycles → BVALID stays 1 and BRESP stable. RREADY held low 5 cycles → RDATA stable. No new ARREADY or AWREADY is asserted meanwhile.
- C_READ_LATENCY=2: RVALID exactly 2 cycles after the ARREADY cycle. Assert ARESET during RWAIT → RVALID never asserts; after release, a fresh read of 0x0 returns the data written before reset.
